mips_mc_controller: RTL

Multicycle control unit for the next-generation MIPS core: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles on a shared instruction/data memory. It replaces the single-cycle combinational controller. It adds:

- a memory-ready handshake (variable-latency memory),
- BNE and ORI as optional, parameter-gated opcodes,
- a sticky illegal-instruction trap.

It sits beside the multicycle datapath, which owns the PC, the instruction register (IR), the register file and the ALU.

---
 rtl/mips_mc_pkg.sv | 56 +++++
 rtl/mips_mc_aludec.sv | 25 ++
 rtl/mips_mc_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - state, opcode, funct, ALU and mux-select encodings for the multicycle controller
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12,
        S_BNEEX   = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_aludec.sv
// rtl/mips_mc_aludec.sv - R-type funct to ALU operation decode with validity flag
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alucontrol,
    output logic       o_funct_valid
);

    always_comb begin
        o_alucontrol  = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_funct)
            FN_ADD:  o_alucontrol = ALU_ADD;
            FN_SUB:  o_alucontrol = ALU_SUB;
            FN_AND:  o_alucontrol = ALU_AND;
            FN_OR:   o_alucontrol = ALU_OR;
            FN_XOR:  o_alucontrol = ALU_XOR;
            FN_NOR:  o_alucontrol = ALU_NOR;
            FN_SLT:  o_alucontrol = ALU_SLT;
            default: o_funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with memory handshake and illegal-op trap
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int EN_BNE        = 1,
    parameter int EN_ORI        = 1,
    parameter int ALUCTRL_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcen,
    output logic                 irwrite,
    output logic                 iord,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic                 zeroext,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic [3:0]           state
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_st;
    logic       w_mr;
    logic [3:0] w_rtype_alu;
    logic       w_funct_valid;
    logic [3:0] w_aluop;

    assign w_mr = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // While reset is held the outputs present FETCH regardless of the stored state.
    assign w_st  = reset ? r_state : S_FETCH;
    assign state = w_st;

    mips_mc_aludec u_aludec (
        .i_funct       (funct),
        .o_alucontrol  (w_rtype_alu),
        .o_funct_valid (w_funct_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:   w_next = w_mr ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_BNE:       w_next = (EN_BNE != 0) ? S_BNEEX : S_TRAP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_ORI:       w_next = (EN_ORI != 0) ? S_ORIEX : S_TRAP;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = w_mr ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = w_mr ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = w_funct_valid ? S_ALUWB : S_TRAP;
            S_ALUWB:   w_next = S_FETCH;
            S_BEQEX:   w_next = S_FETCH;
            S_BNEEX:   w_next = S_FETCH;
            S_ADDIEX:  w_next = S_IMMWB;
            S_ORIEX:   w_next = S_IMMWB;
            S_IMMWB:   w_next = S_FETCH;
            S_JEX:     w_next = S_FETCH;
            default:   w_next = S_TRAP;
        endcase
    end

    always_comb begin
        pcen     = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_B;
        zeroext  = 1'b0;
        pcsrc    = PC_ALU;
        w_aluop  = ALU_ADD;
        illegal  = 1'b0;
        case (w_st)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = w_mr & reset;
                pcen    = w_mr & reset;
            end
            S_DECODE:  alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = w_rtype_alu;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca = 1'b1;
                w_aluop = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pcen    = (w_st == S_BEQEX) ? zero : ~zero;
            end
            S_ADDIEX, S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                if (w_st == S_ORIEX) begin
                    w_aluop = ALU_OR;
                    zeroext = 1'b1;
                end
            end
            S_IMMWB:   regwrite = 1'b1;
            S_JEX: begin
                pcsrc = PC_JUMP;
                pcen  = 1'b1;
            end
            S_TRAP:    illegal = 1'b1;
            default:   ;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(w_aluop);

endmodule
